// File: rtl/float_div_pkg.sv
// Shared types for the iterative float divider.
// FSM states, operand classes, flag bit positions, rounding modes.
package float_div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    ROUND,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    SUBNORM,
    NORMAL,
    INF,
    QNAN,
    SNAN
  } fclass_t;

  localparam int FLAG_INVALID   = 4;
  localparam int FLAG_INFINITE  = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam logic [2:0] RM_NEAR_EVEN    = 3'd0;
  localparam logic [2:0] RM_MIN_MAG      = 3'd1;
  localparam logic [2:0] RM_MIN          = 3'd2;
  localparam logic [2:0] RM_MAX          = 3'd3;
  localparam logic [2:0] RM_NEAR_MAX_MAG = 3'd4;

endpackage

// File: rtl/fn_unpack.sv
// Classifies one float word and normalizes its significand.
// Ports: word in; sign, cls, expo (biased, signed), sig (MSB set if nonzero).
module fn_unpack
  import float_div_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24
) (
  input  logic [expWidth+sigWidth-1:0] word,
  output logic                         sign,
  output fclass_t                      cls,
  output logic signed [expWidth+1:0]   expo,
  output logic [sigWidth-1:0]          sig
);

  localparam int W  = expWidth + sigWidth;
  localparam int EW = expWidth + 2;
  localparam int LW = $clog2(sigWidth + 1);

  logic [expWidth-1:0] e_fld;
  logic [sigWidth-2:0] frac;
  logic [sigWidth-1:0] mant;
  logic [LW-1:0]       lz;
  logic                found;
  logic                e_zero;
  logic                e_ones;

  assign sign   = word[W-1];
  assign e_fld  = word[W-2 -: expWidth];
  assign frac   = word[sigWidth-2:0];
  assign e_zero = ~|e_fld;
  assign e_ones = &e_fld;
  assign mant   = {~e_zero, frac};

  always_comb begin
    lz    = '0;
    found = 1'b0;
    for (int i = sigWidth - 1; i >= 0; i--) begin
      if (!found) begin
        if (mant[i]) found = 1'b1;
        else lz = lz + LW'(1);
      end
    end
  end

  // subnormals use exponent 1, less the normalizing shift
  assign sig  = mant << lz;
  assign expo = EW'(e_fld) + EW'(e_zero) - EW'(lz);

  always_comb begin
    cls = NORMAL;
    if (e_ones) begin
      if (frac == '0) cls = INF;
      else if (frac[sigWidth-2]) cls = QNAN;
      else cls = SNAN;
    end else if (e_zero) begin
      cls = (frac == '0) ? ZERO : SUBNORM;
    end
  end

endmodule

// File: rtl/div_fn.sv
// Iterative IEEE-754 divider, out = a / b, one quotient bit per cycle.
// Ports: clk, reset, val, a, b, roundingMode -> out, exceptionFlags, busy, done.
module div_fn
  import float_div_pkg::*;
#(
  parameter int expWidth = 8,
  parameter int sigWidth = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         val,
  input  logic [expWidth+sigWidth-1:0] a,
  input  logic [expWidth+sigWidth-1:0] b,
  input  logic [2:0]                   roundingMode,
  output logic [expWidth+sigWidth-1:0] out,
  output logic [4:0]                   exceptionFlags,
  output logic                         busy,
  output logic                         done
);

  localparam int W    = expWidth + sigWidth;
  localparam int EW   = expWidth + 2;
  localparam int RW   = sigWidth + 2;
  localparam int CW   = $clog2(sigWidth + 2);
  localparam int BIAS = (1 << (expWidth - 1)) - 1;

  localparam logic signed [EW-1:0] EMAX = EW'((1 << expWidth) - 1);
  localparam logic [CW-1:0] LAST = CW'(sigWidth + 1);

  localparam logic [W-2:0] INF_MAG =
    {{expWidth{1'b1}}, {(sigWidth-1){1'b0}}};
  localparam logic [W-2:0] MAX_MAG =
    {{(expWidth-1){1'b1}}, 1'b0, {(sigWidth-1){1'b1}}};
  localparam logic [W-1:0] QNAN_WORD =
    {1'b0, {expWidth{1'b1}}, 1'b1, {(sigWidth-2){1'b0}}};

  state_t state;
  logic [W-1:0] a_r, b_r;
  logic [2:0] rm_r;
  logic signed [EW-1:0] exp_r;
  logic [RW-1:0] rem, quo;
  logic [sigWidth-1:0] dvs;
  logic [CW-1:0] cnt;

  logic sa, sb;
  fclass_t ca, cb;
  logic signed [EW-1:0] xa, xb;
  logic [sigWidth-1:0] ma, mb;

  fn_unpack #(.expWidth(expWidth), .sigWidth(sigWidth)) u_ua (
    .word(a_r), .sign(sa), .cls(ca), .expo(xa), .sig(ma)
  );

  fn_unpack #(.expWidth(expWidth), .sigWidth(sigWidth)) u_ub (
    .word(b_r), .sign(sb), .cls(cb), .expo(xb), .sig(mb)
  );

  logic signed [EW-1:0] exp_q;
  logic ge;
  logic [RW-1:0] nxt;

  // pre-shifting ma when ma < mb keeps the quotient in [1,2)
  assign exp_q = xa - xb + EW'(BIAS) - EW'(ma < mb);
  assign ge    = rem >= RW'(dvs);
  assign nxt   = ge ? rem - RW'(dvs) : rem;
  assign busy  = (state != IDLE);

  logic sgn, g, rb, st, inx, inc, to_inf, a_nan, b_nan;
  logic [sigWidth:0] sig_rnd;
  logic signed [EW-1:0] exp_f;
  logic [W-1:0] res;
  logic [4:0] fl;
  logic unused_ok;

  assign sgn   = sa ^ sb;
  assign g     = quo[1];
  assign rb    = quo[0];
  assign st    = |rem;
  assign inx   = g | rb | st;
  assign a_nan = (ca == QNAN) || (ca == SNAN);
  assign b_nan = (cb == QNAN) || (cb == SNAN);

  always_comb begin
    inc = 1'b0;
    case (rm_r)
      RM_NEAR_EVEN:    inc = g & (rb | st | quo[2]);
      RM_MIN_MAG:      inc = 1'b0;
      RM_MIN:          inc = sgn & inx;
      RM_MAX:          inc = ~sgn & inx;
      RM_NEAR_MAX_MAG: inc = g;
      default:         inc = 1'b0;
    endcase
  end

  // a carry-out leaves the fraction bits all zero, so only exp moves
  assign sig_rnd   = {1'b0, quo[RW-1:2]} + (sigWidth+1)'(inc);
  assign exp_f     = exp_r + EW'(sig_rnd[sigWidth]);
  assign unused_ok = &{1'b0, sig_rnd[sigWidth-1]};
  assign to_inf    = (rm_r == RM_NEAR_EVEN) || (rm_r == RM_NEAR_MAX_MAG)
                  || ((rm_r == RM_MIN) && sgn) || ((rm_r == RM_MAX) && !sgn);

  always_comb begin
    res = '0;
    fl  = '0;
    if (a_nan || b_nan) begin
      res = QNAN_WORD;
      fl[FLAG_INVALID] = (ca == SNAN) || (cb == SNAN);
    end else if ((ca == ZERO && cb == ZERO) || (ca == INF && cb == INF)) begin
      res = QNAN_WORD;
      fl[FLAG_INVALID] = 1'b1;
    end else if (ca == INF) begin
      res = {sgn, INF_MAG};
    end else if (cb == INF) begin
      res = {sgn, {(W-1){1'b0}}};
    end else if (cb == ZERO) begin
      res = {sgn, INF_MAG};
      fl[FLAG_INFINITE] = 1'b1;
    end else if (ca == ZERO) begin
      res = {sgn, {(W-1){1'b0}}};
    end else if (exp_f >= EMAX) begin
      res = to_inf ? {sgn, INF_MAG} : {sgn, MAX_MAG};
      fl[FLAG_OVERFLOW] = 1'b1;
      fl[FLAG_INEXACT]  = 1'b1;
    end else if (exp_f <= 0) begin
      res = {sgn, {(W-1){1'b0}}};
      fl[FLAG_UNDERFLOW] = 1'b1;
      fl[FLAG_INEXACT]   = 1'b1;
    end else begin
      res = {sgn, exp_f[expWidth-1:0], sig_rnd[sigWidth-2:0]};
      fl[FLAG_INEXACT] = inx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      out            <= '0;
      exceptionFlags <= '0;
      done           <= 1'b0;
      a_r            <= '0;
      b_r            <= '0;
      rm_r           <= '0;
      exp_r          <= '0;
      rem            <= '0;
      quo            <= '0;
      dvs            <= '0;
      cnt            <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (val) begin
            a_r   <= a;
            b_r   <= b;
            rm_r  <= roundingMode;
            state <= NORM;
          end
        end
        NORM: begin
          exp_r <= exp_q;
          rem   <= (ma < mb) ? {1'b0, ma, 1'b0} : {2'b00, ma};
          dvs   <= mb;
          quo   <= '0;
          cnt   <= '0;
          state <= DIV;
        end
        DIV: begin
          quo <= {quo[RW-2:0], ge};
          rem <= {nxt[RW-2:0], 1'b0};
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= ROUND;
        end
        ROUND: begin
          out            <= res;
          exceptionFlags <= fl;
          done           <= 1'b1;
          state          <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_fn.sv
// Self-checking bench for div_fn: directed cases plus random
// operands against an integer-arithmetic reference quotient.
module tb_div_fn;

  logic        clk = 1'b0;
  logic        reset;
  logic        val;
  logic [31:0] a, b;
  logic [2:0]  rm;
  logic [31:0] q;
  logic [4:0]  fl;
  logic        busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  div_fn dut (
    .clk(clk), .reset(reset), .val(val), .a(a), .b(b),
    .roundingMode(rm), .out(q), .exceptionFlags(fl),
    .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [36:0] ref_div(input logic [31:0] x,
      input logic [31:0] y, input logic [2:0] m);
    logic s, xn, yn, xs, ys, xi, yi, xz, yz, up, inx;
    int ex, ey, xu, yu, p, e, sh;
    logic [127:0] mx, my, n, r0, lowb, half, sg;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xs = xn && !x[22];
    ys = yn && !y[22];
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0) && (x[22:0] == 0);
    yz = (ey == 0) && (y[22:0] == 0);
    if (xn || yn) return {32'h7FC00000, xs || ys, 4'b0};
    if ((xz && yz) || (xi && yi)) return {32'h7FC00000, 5'b10000};
    if (xi) return {s, 31'h7F800000, 5'b0};
    if (yi) return {s, 31'h0, 5'b0};
    if (yz) return {s, 31'h7F800000, 5'b01000};
    if (xz) return {s, 31'h0, 5'b0};
    mx = {105'd0, ex != 0, x[22:0]};
    my = {105'd0, ey != 0, y[22:0]};
    xu = (ex == 0 ? 1 : ex) - 150;
    yu = (ey == 0 ? 1 : ey) - 150;
    n  = (mx << 60) / my;
    r0 = (mx << 60) % my;
    p  = 127;
    while (p > 0 && !n[p]) p--;
    sh   = p - 23;
    sg   = n >> sh;
    lowb = n & ((128'd1 << sh) - 1);
    half = 128'd1 << (sh - 1);
    inx  = (lowb != 0) || (r0 != 0);
    case (m)
      3'd0:    up = (lowb > half) || (lowb == half && (r0 != 0 || sg[0]));
      3'd2:    up = s && inx;
      3'd3:    up = !s && inx;
      3'd4:    up = lowb >= half;
      default: up = 1'b0;
    endcase
    sg = sg + up;
    e  = p + xu - yu - 60 + 127;
    if (sg[24]) begin
      sg = sg >> 1;
      e++;
    end
    if (e >= 255) begin
      if (m == 0 || m == 4 || (m == 3 && !s) || (m == 2 && s))
        return {s, 31'h7F800000, 5'b00101};
      return {s, 31'h7F7FFFFF, 5'b00101};
    end
    if (e <= 0) return {s, 31'h0, 5'b00011};
    return {s, e[7:0], sg[22:0], 4'b0, inx};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 11))
      0: w[30:0] = 31'h0;
      1: w[30:0] = 31'h7F800000;
      2: begin
        w[30:23] = 8'hFF;
        if (w[22:0] == 0) w[0] = 1'b1;
      end
      3: w[30:23] = 8'h00;
      4: w[30:23] = 8'($urandom_range(240, 254));
      5: w[30:23] = 8'($urandom_range(1, 12));
      default: w[30:23] = 8'($urandom_range(1, 254));
    endcase
    return w;
  endfunction

  task automatic run(input logic [31:0] xa, input logic [31:0] xb,
                     input logic [2:0] xm, input bit poke,
                     output logic [31:0] o, output logic [4:0] f,
                     output int lat, output int nbusy, output int ndone);
    @(negedge clk);
    a = xa; b = xb; rm = xm; val = 1'b1;
    @(posedge clk); #1;
    val = 1'b0;
    lat = 0; nbusy = 0; ndone = 0;
    o = '0; f = '0;
    if (!busy) nbusy++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (poke && (i == 3 || i == 10)) begin
        val = 1'b1; a = $urandom; b = $urandom;
      end else begin
        val = 1'b0; a = xa; b = xb;
      end
      if (lat == 0 && !busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) begin
          lat = i; o = q; f = fl;
        end
      end
    end
    val = 1'b0;
  endtask

  logic [31:0] ta [10];
  logic [31:0] tb [10];
  logic [2:0]  tm [10];
  logic [31:0] to [10];
  logic [4:0]  tf [10];

  initial begin
    logic [31:0] o, xa, xb;
    logic [4:0] f;
    logic [2:0] xm;
    logic [36:0] w;
    int lat, nb, nd;

    ta[0] = 32'h40C00000; tb[0] = 32'h40000000; tm[0] = 0;
    to[0] = 32'h40400000; tf[0] = 5'b00000;
    ta[1] = 32'h3F800000; tb[1] = 32'h40400000; tm[1] = 0;
    to[1] = 32'h3EAAAAAB; tf[1] = 5'b00001;
    ta[2] = 32'h3F800000; tb[2] = 32'h40400000; tm[2] = 1;
    to[2] = 32'h3EAAAAAA; tf[2] = 5'b00001;
    ta[3] = 32'h3F800000; tb[3] = 32'h00000000; tm[3] = 0;
    to[3] = 32'h7F800000; tf[3] = 5'b01000;
    ta[4] = 32'h00000000; tb[4] = 32'h00000000; tm[4] = 0;
    to[4] = 32'h7FC00000; tf[4] = 5'b10000;
    ta[5] = 32'h7F800001; tb[5] = 32'h3F800000; tm[5] = 0;
    to[5] = 32'h7FC00000; tf[5] = 5'b10000;
    ta[6] = 32'h7F000000; tb[6] = 32'h3E800000; tm[6] = 0;
    to[6] = 32'h7F800000; tf[6] = 5'b00101;
    ta[7] = 32'h7F000000; tb[7] = 32'h3E800000; tm[7] = 1;
    to[7] = 32'h7F7FFFFF; tf[7] = 5'b00101;
    ta[8] = 32'h00400000; tb[8] = 32'h00800000; tm[8] = 0;
    to[8] = 32'h3F000000; tf[8] = 5'b00000;
    ta[9] = 32'h00800000; tb[9] = 32'h7F000000; tm[9] = 0;
    to[9] = 32'h00000000; tf[9] = 5'b00011;

    reset = 1'b1; val = 1'b0; a = '0; b = '0; rm = '0;
    repeat (2) @(negedge clk);
    chk("rst_out", q, 0);
    chk("rst_flags", fl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(ta[i], tb[i], tm[i], 1'b0, o, f, lat, nb, nd);
      chk($sformatf("dir%0d_out", i), o, to[i]);
      chk($sformatf("dir%0d_flags", i), f, tf[i]);
      chk($sformatf("dir%0d_lat", i), lat, 28);
      chk($sformatf("dir%0d_busy", i), nb, 0);
      chk($sformatf("dir%0d_ndone", i), nd, 1);
    end

    run(32'h3F800000, 32'h40400000, 3'd0, 1'b1, o, f, lat, nb, nd);
    chk("poke_out", o, 32'h3EAAAAAB);
    chk("poke_flags", f, 5'b00001);
    chk("poke_lat", lat, 28);
    chk("poke_ndone", nd, 1);

    @(negedge clk);
    a = 32'h40C00000; b = 32'h40000000; rm = 0; val = 1'b1;
    @(posedge clk); #1;
    val = 1'b0;
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_out", q, 0);
    chk("abort_flags", fl, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);

    run(32'h40C00000, 32'h40000000, 3'd0, 1'b0, o, f, lat, nb, nd);
    chk("post_rst_out", o, 32'h40400000);
    chk("post_rst_flags", f, 0);
    chk("post_rst_lat", lat, 28);

    for (int i = 0; i < 200; i++) begin
      xa = rnd_fp();
      xb = rnd_fp();
      xm = 3'($urandom_range(0, 4));
      w  = ref_div(xa, xb, xm);
      run(xa, xb, xm, 1'b0, o, f, lat, nb, nd);
      chk($sformatf("rnd%0d_out %h/%h m%0d", i, xa, xb, xm), o, w[36:5]);
      chk($sformatf("rnd%0d_flags", i), f, w[4:0]);
      chk($sformatf("rnd%0d_lat", i), lat, 28);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
